// File: rtl/dp_trace_buffer_pkg.sv
// Shared definitions for the datapath trace buffer: capture FSM encoding
// and the width of one stored trace entry.
package dp_trace_buffer_pkg;

  // Capture sequencing: idle, pre-trigger history, post-trigger fill, complete.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } trace_state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_STATE_W = 5;

  // One entry holds {PC, IROut, ALU_Out, current_state}.
  localparam int ENTRY_W = 3 * DEF_DATA_W + DEF_STATE_W;

  // Entry width for a non-default instantiation.
  function automatic int entry_width(input int data_w, input int state_w);
    return 3 * data_w + state_w;
  endfunction

endpackage

// File: rtl/dp_trace_buffer_trace_ram.sv
// Trace storage: one write port and one registered read port. The contents
// are never reset; a read of the word written in the same cycle returns the
// previous contents.
module dp_trace_buffer_trace_ram #(
  parameter int WIDTH = 53,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write one sample per enabled cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read; old data is returned on a same-address write.
  always_ff @(posedge i_clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dp_trace_buffer.sv
// Datapath trace buffer: records {PC, IROut, ALU_Out, current_state} into a
// circular history, stops a fixed number of samples after a PC-match or
// forced trigger, and offers a chronological read port (index 0 = oldest).
module dp_trace_buffer
  import dp_trace_buffer_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int STATE_W     = 5,
  parameter int DEPTH       = 32,
  parameter int POST_TRIG   = 16,
  parameter int FETCH_STATE = 0
) (
  input  logic                                CLK,
  input  logic                                Reset,
  input  logic                                Arm,
  input  logic                                Mode,
  input  logic                                TrigEn,
  input  logic [DATA_W-1:0]                   TrigPC,
  input  logic                                ForceTrig,
  input  logic [DATA_W-1:0]                   PC,
  input  logic [DATA_W-1:0]                   IROut,
  input  logic [DATA_W-1:0]                   ALU_Out,
  input  logic [STATE_W-1:0]                  current_state,
  input  logic [$clog2(DEPTH)-1:0]            RdAddr,
  output logic [3*DATA_W+STATE_W-1:0]         RdData,
  output logic [$clog2(DEPTH):0]              Count,
  output logic                                Armed,
  output logic                                Triggered,
  output logic                                Done,
  output logic [$clog2(DEPTH)-1:0]            TrigIndex
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_width(DATA_W, STATE_W);

  localparam logic [AW:0]        DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]      POST_L  = AW'(POST_TRIG);
  localparam logic [AW-1:0]      ONE_L   = AW'(1);
  localparam logic [STATE_W-1:0] FETCH_L = STATE_W'(FETCH_STATE);

  trace_state_t   r_state;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_post_cnt;
  logic [AW-1:0]  r_trig_idx;
  logic [AW:0]    r_count;
  logic           r_rd_valid;

  logic           w_capturing;
  logic           w_sample;
  logic           w_trig_hit;
  logic           w_post_last;
  logic [AW-1:0]  w_post_inc;
  logic [AW:0]    w_count_inc;
  logic [AW-1:0]  w_rd_phys;
  logic [EW-1:0]  w_entry;
  logic [EW-1:0]  w_ram_q;

  // A sample is taken while capturing, gated by instruction mode; the Arm
  // cycle itself never samples because Arm restarts the capture.
  assign w_capturing = (r_state == ST_PRE) || (r_state == ST_POST);
  assign w_sample    = w_capturing && !Arm && (!Mode || (current_state == FETCH_L));
  assign w_trig_hit  = ForceTrig || (TrigEn && (PC == TrigPC));

  assign w_count_inc = (r_count == DEPTH_L) ? r_count : r_count + 1'b1;
  assign w_post_inc  = r_post_cnt + ONE_L;
  assign w_post_last = (w_post_inc == POST_L);

  assign w_entry = {PC, IROut, ALU_Out, current_state};

  // Oldest valid entry sits Count slots behind the write pointer; when full
  // the low bits of Count are zero so the oldest is at the write pointer.
  assign w_rd_phys = r_wr_ptr - r_count[AW-1:0] + RdAddr;

  // Capture sequencing, write pointer, fill count and trigger position.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_trig_idx <= '0;
    end else if (Arm) begin
      r_state    <= ST_PRE;
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_trig_idx <= '0;
    end else begin
      if (w_sample) begin
        r_wr_ptr <= r_wr_ptr + ONE_L;
        r_count  <= w_count_inc;
      end
      case (r_state)
        ST_PRE: begin
          if (w_sample && w_trig_hit) begin
            r_state    <= ST_POST;
            r_post_cnt <= '0;
          end
        end
        ST_POST: begin
          if (w_sample) begin
            r_post_cnt <= w_post_inc;
            if (w_post_last) begin
              r_state    <= ST_DONE;
              // Trigger sample is POST_TRIG entries before the newest one.
              r_trig_idx <= w_count_inc[AW-1:0] - ONE_L - POST_L;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Remember whether the requested index held a valid entry so that the
  // registered RAM output can be masked to zero otherwise.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= ({1'b0, RdAddr} < r_count);
    end
  end

  dp_trace_buffer_trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) trace_ram (
    .i_clk   (CLK),
    .i_we    (w_sample),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_entry),
    .i_raddr (w_rd_phys),
    .o_rdata (w_ram_q)
  );

  assign RdData    = r_rd_valid ? w_ram_q : '0;
  assign Count     = r_count;
  assign Armed     = (r_state == ST_PRE) || (r_state == ST_POST);
  assign Triggered = (r_state == ST_POST) || (r_state == ST_DONE);
  assign Done      = (r_state == ST_DONE);
  assign TrigIndex = r_trig_idx;

endmodule

// File: tb/tb_dp_trace_buffer.sv
// Bench for dp_trace_buffer (DEPTH=8, POST_TRIG=4, FETCH_STATE=0): directed
// scenarios followed by randomized traffic, all checked against a
// queue-based model of the capture rules.
module tb_dp_trace_buffer;

  localparam int DW    = 16;
  localparam int SW    = 5;
  localparam int DEPTH = 8;
  localparam int PT    = 4;
  localparam int AW    = 3;
  localparam int EW    = 3 * DW + SW;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Arm;
  logic          Mode;
  logic          TrigEn;
  logic [DW-1:0] TrigPC;
  logic          ForceTrig;
  logic [DW-1:0] PC;
  logic [DW-1:0] IROut;
  logic [DW-1:0] ALU_Out;
  logic [SW-1:0] current_state;
  logic [AW-1:0] RdAddr;
  logic [EW-1:0] RdData;
  logic [AW:0]   Count;
  logic          Armed;
  logic          Triggered;
  logic          Done;
  logic [AW-1:0] TrigIndex;

  dp_trace_buffer #(
    .DATA_W      (DW),
    .STATE_W     (SW),
    .DEPTH       (DEPTH),
    .POST_TRIG   (PT),
    .FETCH_STATE (0)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .Arm           (Arm),
    .Mode          (Mode),
    .TrigEn        (TrigEn),
    .TrigPC        (TrigPC),
    .ForceTrig     (ForceTrig),
    .PC            (PC),
    .IROut         (IROut),
    .ALU_Out       (ALU_Out),
    .current_state (current_state),
    .RdAddr        (RdAddr),
    .RdData        (RdData),
    .Count         (Count),
    .Armed         (Armed),
    .Triggered     (Triggered),
    .Done          (Done),
    .TrigIndex     (TrigIndex)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the valid history as a queue (oldest first, at most
  // DEPTH entries), a phase (0 idle, 1 pre, 2 post, 3 done) and the number
  // of samples taken since the trigger.
  logic [EW-1:0] m_q[$];
  int            m_phase = 0;
  int            m_post  = 0;

  task automatic model_update();
    if (Reset) begin
      m_q.delete();
      m_phase = 0;
      m_post  = 0;
    end else if (Arm) begin
      m_q.delete();
      m_phase = 1;
      m_post  = 0;
    end else if ((m_phase == 1 || m_phase == 2) && (!Mode || current_state == 0)) begin
      m_q.push_back({PC, IROut, ALU_Out, current_state});
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      if (m_phase == 1) begin
        if (ForceTrig || (TrigEn && PC == TrigPC)) begin
          m_phase = 2;
          m_post  = 0;
        end
      end else begin
        m_post++;
        if (m_post == PT) m_phase = 3;
      end
    end
  endtask

  // One clock: predict read data from the pre-edge history, advance the
  // model with the inputs present at the edge, then compare just after it.
  task automatic tick(input string tag);
    logic [EW-1:0] exp_rd;
    int            exp_ti;
    exp_rd = '0;
    if (!Reset && int'(RdAddr) < m_q.size()) exp_rd = m_q[RdAddr];
    @(posedge CLK);
    model_update();
    #1;
    exp_ti = (m_phase == 3) ? (m_q.size() - 1 - PT) : 0;
    check({tag, "_count"}, 64'(Count), 64'(m_q.size()));
    check({tag, "_armed"}, 64'(Armed), 64'(m_phase == 1 || m_phase == 2));
    check({tag, "_trig"},  64'(Triggered), 64'(m_phase >= 2));
    check({tag, "_done"},  64'(Done), 64'(m_phase == 3));
    check({tag, "_tidx"},  64'(TrigIndex), 64'(exp_ti));
    check({tag, "_rd"},    64'(RdData), 64'(exp_rd));
  endtask

  task automatic quiet_inputs();
    Arm       = 1'b0;
    Mode      = 1'b0;
    TrigEn    = 1'b0;
    TrigPC    = '0;
    ForceTrig = 1'b0;
    PC        = '0;
    IROut     = '0;
    ALU_Out   = '0;
    current_state = '0;
    RdAddr    = '0;
  endtask

  task automatic rand_payload();
    IROut   = DW'($urandom);
    ALU_Out = DW'($urandom);
  endtask

  initial begin
    Reset = 1'b1;
    quiet_inputs();
    tick("rst0");
    tick("rst1");
    Reset = 1'b0;
    tick("rst_rel");
    check("rst_count", 64'(Count), 64'd0);
    check("rst_flags", 64'({Armed, Triggered, Done}), 64'd0);

    // Trigger inputs while idle are ignored.
    ForceTrig = 1'b1; TrigEn = 1'b1;
    tick("idle_trig");
    ForceTrig = 1'b0; TrigEn = 1'b0;

    // PC-match capture; the Arm cycle itself carries a matching PC.
    TrigEn = 1'b1; TrigPC = 16'h0005; PC = 16'h0005; Arm = 1'b1;
    tick("t1_arm");
    check("t1_arm_armed", 64'(Armed), 64'd1);
    check("t1_arm_trig", 64'(Triggered), 64'd0);
    Arm = 1'b0;
    for (int i = 0; i < 12; i++) begin
      PC = DW'(i); rand_payload(); RdAddr = AW'($urandom);
      tick("t1_run");
    end
    check("t1_done", 64'(Done), 64'd1);
    check("t1_count", 64'(Count), 64'd8);
    check("t1_tidx", 64'(TrigIndex), 64'd3);
    for (int r = 0; r < DEPTH; r++) begin
      RdAddr = AW'(r);
      tick("t1_rd");
      check("t1_rd_pc", 64'(RdData[EW-1 -: DW]), 64'(r + 2));
    end

    // Forced trigger on the second sampled cycle.
    TrigEn = 1'b0; Arm = 1'b1;
    tick("t2_arm");
    Arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      PC = DW'(i); rand_payload(); ForceTrig = (i == 1);
      tick("t2_run");
    end
    ForceTrig = 1'b0;
    check("t2_count", 64'(Count), 64'd6);
    check("t2_tidx", 64'(TrigIndex), 64'd1);
    for (int r = 0; r < 7; r++) begin
      RdAddr = AW'(r);
      tick("t2_rd");
      check("t2_rd_pc", 64'(RdData[EW-1 -: DW]), (r < 6) ? 64'(r) : 64'd0);
    end

    // Instruction mode: only state-0 cycles are stored.
    Mode = 1'b1; Arm = 1'b1; current_state = 5'd3;
    tick("t3_arm");
    Arm = 1'b0;
    for (int i = 0; i < 35; i++) begin
      PC = DW'(i); rand_payload(); current_state = SW'(i % 5); ForceTrig = (i == 10);
      tick("t3_run");
    end
    ForceTrig = 1'b0;
    check("t3_count", 64'(Count), 64'd7);
    check("t3_tidx", 64'(TrigIndex), 64'd2);
    for (int r = 0; r < 7; r++) begin
      RdAddr = AW'(r);
      tick("t3_rd");
      check("t3_rd_st", 64'(RdData[SW-1:0]), 64'd0);
      check("t3_rd_pc", 64'(RdData[EW-1 -: DW]), 64'(r * 5));
    end
    Mode = 1'b0; current_state = '0;

    // Re-arm while in POST.
    Arm = 1'b1;
    tick("t4_arm");
    Arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PC = DW'(i + 100); rand_payload(); ForceTrig = (i == 1);
      tick("t4_run");
    end
    ForceTrig = 1'b0;
    check("t4_in_post", 64'(Triggered && !Done), 64'd1);
    Arm = 1'b1;
    tick("t4_rearm");
    check("t4_count", 64'(Count), 64'd0);
    check("t4_trig", 64'(Triggered), 64'd0);
    check("t4_armed", 64'(Armed), 64'd1);
    Arm = 1'b0;

    // Reset three samples into POST; takes effect without a clock edge.
    ForceTrig = 1'b1; PC = 16'h0040;
    tick("t5_trig");
    ForceTrig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      PC = DW'(i + 65); rand_payload();
      tick("t5_post");
    end
    RdAddr = '0;
    Reset = 1'b1;
    #1;
    check("t5_async_count", 64'(Count), 64'd0);
    check("t5_async_flags", 64'({Armed, Triggered, Done}), 64'd0);
    check("t5_async_tidx", 64'(TrigIndex), 64'd0);
    check("t5_async_rd", 64'(RdData), 64'd0);
    tick("t5_hold");
    Reset = 1'b0;
    TrigEn = 1'b1; TrigPC = 16'h0077; PC = 16'h0077; ForceTrig = 1'b1;
    for (int i = 0; i < 3; i++) tick("t5_ignored");
    check("t5_idle_armed", 64'(Armed), 64'd0);
    quiet_inputs();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      Arm       = ($urandom_range(39) == 0);
      ForceTrig = ($urandom_range(29) == 0);
      TrigEn    = 1'($urandom);
      TrigPC    = DW'($urandom_range(15));
      PC        = DW'($urandom_range(15));
      rand_payload();
      if ($urandom_range(99) == 0) Mode = ~Mode;
      current_state = SW'($urandom_range(4));
      RdAddr    = AW'($urandom);
      Reset     = ($urandom_range(499) == 0);
      tick("rnd");
    end
    Reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
